pipelined_rca: RTL and testbench

PIPELINED_RCA -- requirements
Module: pipelined_rca

---
 rtl/pipelined_rca_pkg.sv | 21 ++
 rtl/pipelined_rca_slice.sv | 23 ++
 rtl/pipelined_rca.sv | 107 ++++++++++
 tb/tb_pipelined_rca.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_rca_pkg.sv
// Shared defaults and stage-record layout for the pipelined ripple-carry adder.
// Each stage carries a control record plus full-width operand and partial-sum words.
package pipelined_rca_pkg;

   localparam int DEF_WIDTH  = 8;
   localparam int DEF_STAGES = 2;

   // Control half of a stage record; the operand slices still to be added and
   // the partial sum travel beside it as WIDTH-bit words.
   typedef struct packed {
      logic vld;
      logic sub;
      logic carry;
   } stage_ctrl_t;

   // Subtraction is x + ~y + 1, so the incoming carry is forced high.
   function automatic logic eff_cin(input logic sub, input logic ci);
      return sub | ci;
   endfunction

endpackage

// File: rtl/pipelined_rca_slice.sv
// Combinational ripple-carry slice of parametrised width.
module rca_slice #(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout
);

   always_comb begin
      logic c;
      c   = cin;
      sum = '0;
      for (int i = 0; i < W; i++) begin
         sum[i] = a[i] ^ b[i] ^ c;
         c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      cout = c;
   end

endmodule

// File: rtl/pipelined_rca.sv
// Pipelined adder/subtractor: one ripple slice per stage, LSB slice first,
// carry and untouched operand slices registered between stages.
module pipelined_rca
   import pipelined_rca_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int STAGES = DEF_STAGES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             sub,
   input  logic             ci,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             co,
   output logic             ovf
);

   localparam int SW = WIDTH / STAGES;

   if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
      $error("pipelined_rca: WIDTH must be >= 2 and a multiple of STAGES");
   end

   logic             adv;
   stage_ctrl_t      ctrl_src [STAGES];
   stage_ctrl_t      ctrl_q   [STAGES];
   logic [WIDTH-1:0] a_src    [STAGES];
   logic [WIDTH-1:0] b_src    [STAGES];
   logic [WIDTH-1:0] sum_src  [STAGES];
   logic [WIDTH-1:0] sum_nxt  [STAGES];
   logic [WIDTH-1:0] a_q      [STAGES];
   logic [WIDTH-1:0] b_q      [STAGES];
   logic [WIDTH-1:0] sum_q    [STAGES];
   logic [WIDTH-1:0] slice_sum;
   logic [STAGES-1:0] slice_co;
   logic             ovf_nxt;
   logic             ovf_q;

   // The whole pipe moves as one: it only stalls when a finished result is
   // waiting on the consumer.
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   always_comb begin
      a_src[0]    = x;
      b_src[0]    = sub ? ~y : y;
      sum_src[0]  = '0;
      ctrl_src[0] = '{vld: in_valid, sub: sub, carry: eff_cin(sub, ci)};
      for (int k = 1; k < STAGES; k++) begin
         a_src[k]    = a_q[k-1];
         b_src[k]    = b_q[k-1];
         sum_src[k]  = sum_q[k-1];
         ctrl_src[k] = ctrl_q[k-1];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_slice
      rca_slice #(.W(SW)) u_slice (
         .a   (a_src[k][k*SW +: SW]),
         .b   (b_src[k][k*SW +: SW]),
         .cin (ctrl_src[k].carry),
         .sum (slice_sum[k*SW +: SW]),
         .cout(slice_co[k])
      );
   end

   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         sum_nxt[k]              = sum_src[k];
         sum_nxt[k][k*SW +: SW]  = slice_sum[k*SW +: SW];
      end
      ovf_nxt = (a_src[STAGES-1][WIDTH-1] == b_src[STAGES-1][WIDTH-1]) &&
                (sum_nxt[STAGES-1][WIDTH-1] != a_src[STAGES-1][WIDTH-1]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            ctrl_q[k] <= '0;
            a_q[k]    <= '0;
            b_q[k]    <= '0;
            sum_q[k]  <= '0;
         end
         ovf_q <= 1'b0;
      end else if (adv) begin
         for (int k = 0; k < STAGES; k++) begin
            ctrl_q[k] <= '{vld: ctrl_src[k].vld, sub: ctrl_src[k].sub, carry: slice_co[k]};
            a_q[k]    <= a_src[k];
            b_q[k]    <= b_src[k];
            sum_q[k]  <= sum_nxt[k];
         end
         ovf_q <= ovf_nxt;
      end
   end

   assign out_valid = ctrl_q[STAGES-1].vld;
   assign s         = sum_q[STAGES-1];
   assign co        = ctrl_q[STAGES-1].carry;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_rca.sv
// Scoreboard bench driving three configurations (8/2, 16/4, 8/1) from one stimulus stream.
module tb_pipelined_rca;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, tsub, tci, out_ready;
   logic [15:0] tx, ty;

   logic        rdy_a, ov_a, co_a, ovf_a;
   logic [7:0]  s_a;
   logic        rdy_b, ov_b, co_b, ovf_b;
   logic [15:0] s_b;
   logic        rdy_c, ov_c, co_c, ovf_c;
   logic [7:0]  s_c;

   int errors = 0;
   int checks = 0;
   logic [17:0] q_a[$];
   logic [17:0] q_b[$];
   logic [17:0] q_c[$];

   always #5 clk = ~clk;

   pipelined_rca #(.WIDTH(8), .STAGES(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a),
      .x(tx[7:0]), .y(ty[7:0]), .sub(tsub), .ci(tci),
      .out_valid(ov_a), .out_ready(out_ready), .s(s_a), .co(co_a), .ovf(ovf_a));

   pipelined_rca #(.WIDTH(16), .STAGES(4)) u_w16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_b),
      .x(tx), .y(ty), .sub(tsub), .ci(tci),
      .out_valid(ov_b), .out_ready(out_ready), .s(s_b), .co(co_b), .ovf(ovf_b));

   pipelined_rca #(.WIDTH(8), .STAGES(1)) u_w8s1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_c),
      .x(tx[7:0]), .y(ty[7:0]), .sub(tsub), .ci(tci),
      .out_valid(ov_c), .out_ready(out_ready), .s(s_c), .co(co_c), .ovf(ovf_c));

   // Reference from integer arithmetic: {ovf, co, s[15:0]}.
   function automatic logic [17:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                         input logic sb, input logic c);
      longint mask, half, ua, ub, sa, sbv, ru, rs;
      logic coe, ovfe;
      mask = (longint'(1) << w) - 1;
      half = longint'(1) << (w - 1);
      ua   = longint'(a) & mask;
      ub   = longint'(b) & mask;
      sa   = (ua >= half) ? ua - (mask + 1) : ua;
      sbv  = (ub >= half) ? ub - (mask + 1) : ub;
      if (sb) begin
         ru  = ua - ub;
         coe = (ua >= ub);
         rs  = sa - sbv;
      end else begin
         ru  = ua + ub + longint'(c);
         coe = (ru > mask);
         rs  = sa + sbv + longint'(c);
      end
      ovfe = (rs >= half) || (rs < -half);
      return {ovfe, coe, 16'(ru & mask)};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin : mon_a
      logic [17:0] e;
      if (!rst_n) q_a.delete();
      else begin
         if (in_valid && rdy_a) q_a.push_back(model(8, tx, ty, tsub, tci));
         if (ov_a && out_ready) begin
            if (q_a.size() == 0) check("w8s2 unexpected result", 32'(ov_a), 32'd0);
            else begin
               e = q_a.pop_front();
               check("w8s2 s", 32'(s_a), 32'(e[7:0]));
               check("w8s2 co", 32'(co_a), 32'(e[16]));
               check("w8s2 ovf", 32'(ovf_a), 32'(e[17]));
            end
         end
      end
   end

   always @(negedge clk) begin : mon_b
      logic [17:0] e;
      if (!rst_n) q_b.delete();
      else begin
         if (in_valid && rdy_b) q_b.push_back(model(16, tx, ty, tsub, tci));
         if (ov_b && out_ready) begin
            if (q_b.size() == 0) check("w16s4 unexpected result", 32'(ov_b), 32'd0);
            else begin
               e = q_b.pop_front();
               check("w16s4 s", 32'(s_b), 32'(e[15:0]));
               check("w16s4 co", 32'(co_b), 32'(e[16]));
               check("w16s4 ovf", 32'(ovf_b), 32'(e[17]));
            end
         end
      end
   end

   always @(negedge clk) begin : mon_c
      logic [17:0] e;
      if (!rst_n) q_c.delete();
      else begin
         if (in_valid && rdy_c) q_c.push_back(model(8, tx, ty, tsub, tci));
         if (ov_c && out_ready) begin
            if (q_c.size() == 0) check("w8s1 unexpected result", 32'(ov_c), 32'd0);
            else begin
               e = q_c.pop_front();
               check("w8s1 s", 32'(s_c), 32'(e[7:0]));
               check("w8s1 co", 32'(co_c), 32'(e[16]));
               check("w8s1 ovf", 32'(ovf_c), 32'(e[17]));
            end
         end
      end
   end

   // Presents one operand set and holds it until the 8/2 DUT accepts it.
   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic sb,
                       input logic c, input bit rnd);
      logic acc;
      int   n;
      tx = a; ty = b; tsub = sb; tci = c; in_valid = 1'b1;
      acc = 1'b0; n = 0;
      while (!acc && n < 100) begin
         if (rnd) out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         acc = rdy_a;
         @(posedge clk);
         #1;
         n++;
      end
      in_valid = 1'b0;
      if (!acc) check("send timeout", 32'(acc), 32'd1);
   endtask

   task automatic directed(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic sb, input logic c,
                           input logic [7:0] es, input logic eco, input logic eovf);
      send(a, b, sb, c, 1'b0);
      @(negedge clk);
      check({tag, " early valid"}, 32'(ov_a), 32'd0);
      @(posedge clk);
      #1;
      check({tag, " valid"}, 32'(ov_a), 32'd1);
      check({tag, " s"}, 32'(s_a), 32'(es));
      check({tag, " co"}, 32'(co_a), 32'(eco));
      check({tag, " ovf"}, 32'(ovf_a), 32'(eovf));
   endtask

   initial begin
      int n;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      tx = '0; ty = '0; tsub = 1'b0; tci = 1'b0;
      #1;
      check("reset out_valid", 32'(ov_a), 32'd0);
      check("reset in_ready", 32'(rdy_a), 32'd1);
      check("reset s", 32'(s_a), 32'd0);
      check("reset co/ovf", 32'({co_a, ovf_a}), 32'd0);
      check("reset others valid", 32'({ov_b, ov_c}), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      directed("add 0F+01", 16'h0F, 16'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
      directed("add FF+01", 16'hFF, 16'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      directed("add 7F+01", 16'h7F, 16'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
      directed("sub 05-07", 16'h05, 16'h07, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0);
      directed("sub 80-01", 16'h80, 16'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1);
      directed("add ci 7F+00+1", 16'h7F, 16'h00, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1);

      // Back-to-back stream with a three-cycle consumer stall.
      send(16'h00, 16'h00, 1'b0, 1'b0, 1'b0);
      send(16'h01, 16'h01, 1'b0, 1'b0, 1'b0);
      send(16'h0F, 16'h01, 1'b0, 1'b0, 1'b0);
      out_ready = 1'b0;
      tx = 16'hF0; ty = 16'h0F; in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("stall in_ready", 32'(rdy_a), 32'd0);
         check("stall out_valid", 32'(ov_a), 32'd1);
         check("stall s held", 32'(s_a), 32'h02);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      send(16'hF0, 16'h0F, 1'b0, 1'b0, 1'b0);
      send(16'hFF, 16'h01, 1'b0, 1'b0, 1'b0);
      send(16'hAA, 16'h55, 1'b0, 1'b0, 1'b0);
      repeat (6) @(posedge clk);
      #1;

      // Asynchronous reset with two operations in flight.
      send(16'h11, 16'h22, 1'b0, 1'b0, 1'b0);
      send(16'h33, 16'h44, 1'b0, 1'b1, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("async rst out_valid", 32'(ov_a), 32'd0);
      check("async rst s", 32'(s_a), 32'd0);
      check("async rst in_ready", 32'(rdy_a), 32'd1);
      check("async rst others valid", 32'({ov_b, ov_c}), 32'd0);
      @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("post-reset idle", 32'(ov_a), 32'd0);
      end
      @(posedge clk);
      #1;
      directed("post-reset 0F+01", 16'h0F, 16'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);

      // Random traffic with random back-pressure and bubbles.
      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
         end
         send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'b1);
      end

      out_ready = 1'b1;
      in_valid  = 1'b0;
      n = 0;
      while ((q_a.size() != 0 || q_b.size() != 0 || q_c.size() != 0) && n < 50) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("drain w8s2", 32'(q_a.size()), 32'd0);
      check("drain w16s4", 32'(q_b.size()), 32'd0);
      check("drain w8s1", 32'(q_c.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
